regfile_sequencer: RTL and testbench
====================================

// Module: regfile_sequencer
// PURPOSE
// - Multi-cycle instruction sequencer and ALU that sits directly upstream of the 8x10-bit register file.
// - Drives the register file's D, ENW, ENR0, WRA, RDA0 and RDA1 inputs, and consumes its Q0/Q1 read ports.
// - Executes one 10-bit instruction per EXECUTE request: load, move or ALU op, then write back to Rx.
// PARAMETERS
// - W      10  datapath width; equals the register-file width
// - AW     3   register address width (8 registers)
// PORTS
// - CLKb     in   1     clock; all state updates on the rising edge
// - RST      in   1     asynchronous active-high reset
// - INSTR    in   W     instruction: [9:6] opcode, [5:3] Rx, [2:0] Ry
// - EXECUTE  in   1     start request, sampled in IDLE only
// - DIN      in   W     external data for LOAD
// - Q0       in   W     register-file read port 0 (Rx)
// - Q1       in   W     register-file read port 1 (Ry)
// - D        out  W     write data to register file
// - ENW      out  1     register-file write enable
// - ENR0     out  1     register-file read-port-0 enable
// - WRA      out  AW    write address
// - RDA0     out  AW    read address 0
// - RDA1     out  AW    read address 1
// - BUSY     out  1     instruction in progress (state != IDLE)
// - DONE     out  1     one-cycle pulse in the write-back/complete cycle
// BEHAVIOUR
// - Reset (async, RST=1): state=IDLE; IR=A=B=G=0; all outputs 0.
//   - Reset mid-instruction aborts immediately: ENW drops asynchronously and no write occurs.
// - Registers: IR (instruction), A/B (operands), G (result). All outputs are Moore outputs, decoded from state and IR.
// - IDLE:
//   - EXECUTE=1 latches INSTR into IR and goes to T1.
//   - All enables and addresses are 0.
// - T1 (read):
//   - RDA0=IR.Rx, RDA1=IR.Ry, ENR0=1.
//   - A<=Q0, B<=Q1.
//   - LOAD: G<=DIN, go to T3.
//   - Illegal opcode: go to T3 with the write suppressed.
//   - Otherwise go to T2.
// - T2 (execute): G <= ALU(A,B), go to T3.
// - T3 (write-back):
//   - D=G, WRA=IR.Rx, ENW=1 except for an illegal opcode.
//   - DONE=1, go to IDLE; the register-file write lands on the edge leaving T3.
// - Latency from the EXECUTE-sampling edge to the write edge:
//   - ALU ops and MOV: 3 edges.
//   - LOAD and illegal opcode: 2 edges.
// - Back-to-back operation: EXECUTE held high restarts on the edge leaving T3 → IDLE; the next sample occurs in IDLE (1 idle cycle minimum).
// - EXECUTE while BUSY is ignored; INSTR changes after latch have no effect.
// - Opcodes:
//   - 0000 LOAD Rx<-DIN
//   - 0001 MOV Rx<-Ry
//   - 0010 ADD Rx<-Rx+Ry
//   - 0011 SUB Rx<-Rx-Ry
//   - 0100 INV Rx<-~Ry
//   - 0101 AND
//   - 0110 OR
//   - 0111 XOR
//   - 1000-1111 illegal: no write, DONE still pulses.
// - Arithmetic: unsigned, modulo 2^W (wrap-around); SUB = A + ~B + 1.
// - Rx==Ry is legal (e.g. ADD R2,R2 doubles R2); both read ports are driven with the same address.
// CONFIGURATION
// - Macro RFSEQ_FLAGS_EN defined:
//   - Adds outputs Z (1) and C (1), registered in T2 for ADD/SUB only and held otherwise; reset 0.
//   - Z=1 when the result is 0.
//   - C = carry-out for ADD; C = borrow (A<B) for SUB.
//   - Other opcodes leave Z and C unchanged.
// - Macro not defined: no Z/C ports or logic; behaviour is otherwise identical.
// TESTING
// - Reset: assert RST mid-sim -> all outputs 0, BUSY=0, state IDLE.
// - LOAD: INSTR=0x018 (R3), DIN=0x155, pulse EXECUTE -> ENR0=1 next cycle, then ENW=1, WRA=3, D=0x155, DONE=1; 2 edges total.
// - ADD: R1=0x3FF, R2=0x001; INSTR=0x08A -> D=0x000 to WRA=1 on the 3rd edge; with RFSEQ_FLAGS_EN, Z=1 and C=1.
// - SUB: R4=5, R5=7; INSTR=0x0E5 -> D=0x3FE to WRA=4; with RFSEQ_FLAGS_EN, C=1 and Z=0.
// - Busy/illegal: EXECUTE held high with a new INSTR during T1/T2 -> ignored. INSTR=0x200 -> ENW stays 0, DONE pulses once.
// - Abort: assert RST during T2 of ADD -> ENW never asserts, the target register is unchanged, and BUSY falls immediately.

Source files
------------

// File: rtl/regfile_sequencer.sv
// Multi-cycle instruction sequencer and ALU placed in front of an 8 x W-bit register file.
// Runs one instruction per EXECUTE request: IDLE -> T1 (read) -> [T2 (execute)] -> T3 (write-back).
// Every output is a Moore decode of the state and the latched instruction.
// Optional feature: define RFSEQ_FLAGS_EN to add the Z/C flag outputs, which ADD/SUB update.
module regfile_sequencer #(
  parameter int unsigned W  = 10,
  parameter int unsigned AW = 3
) (
  input  logic          CLKb,
  input  logic          RST,
  input  logic [W-1:0]  INSTR,
  input  logic          EXECUTE,
  input  logic [W-1:0]  DIN,
  input  logic [W-1:0]  Q0,
  input  logic [W-1:0]  Q1,
  output logic [W-1:0]  D,
  output logic          ENW,
  output logic          ENR0,
  output logic [AW-1:0] WRA,
  output logic [AW-1:0] RDA0,
  output logic [AW-1:0] RDA1,
  output logic          BUSY,
`ifdef RFSEQ_FLAGS_EN
  output logic          Z,
  output logic          C,
`endif
  output logic          DONE
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StT1   = 2'd1,
    StT2   = 2'd2,
    StT3   = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    OpLoad = 4'h0,
    OpMov  = 4'h1,
    OpAdd  = 4'h2,
    OpSub  = 4'h3,
    OpInv  = 4'h4,
    OpAnd  = 4'h5,
    OpOr   = 4'h6,
    OpXor  = 4'h7
  } op_e;

  state_e         state_q, state_d;
  logic [W-1:0]   ir_q, ir_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   g_q, g_d;

  // Instruction fields: opcode in the top four bits, then Rx, then Ry.
  logic [3:0]     op;
  logic [AW-1:0]  rx;
  logic [AW-1:0]  ry;
  logic           op_illegal;

  assign op         = ir_q[W-1 -: 4];
  assign rx         = ir_q[2*AW-1:AW];
  assign ry         = ir_q[AW-1:0];
  assign op_illegal = op[3];

  // ALU result and carry; ADD and SUB share one adder, with SUB computed as A + ~B + 1.
  logic [W-1:0]   alu_res;
  logic           alu_carry;
  logic [W:0]     sum_ext;
  logic           is_sub;

  assign is_sub = (op == OpSub);

  // Adder operand inversion for SUB; the carry out is the inverse of the borrow.
  always_comb begin
    if (is_sub) begin
      sum_ext = {1'b0, a_q} + {1'b0, ~b_q} + {{W{1'b0}}, 1'b1};
    end else begin
      sum_ext = {1'b0, a_q} + {1'b0, b_q};
    end
  end

  // Decode the latched opcode into a result and a carry/borrow flag.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op)
      OpMov: alu_res = b_q;
      OpAdd: begin
        alu_res   = sum_ext[W-1:0];
        alu_carry = sum_ext[W];
      end
      OpSub: begin
        alu_res   = sum_ext[W-1:0];
        alu_carry = ~sum_ext[W];
      end
      OpInv: alu_res = ~b_q;
      OpAnd: alu_res = a_q & b_q;
      OpOr:  alu_res = a_q | b_q;
      OpXor: alu_res = a_q ^ b_q;
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

`ifdef RFSEQ_FLAGS_EN
  logic z_q, z_d;
  logic c_q, c_d;
`endif

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    g_d     = g_q;
`ifdef RFSEQ_FLAGS_EN
    z_d     = z_q;
    c_d     = c_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (EXECUTE) begin
          ir_d    = INSTR;
          state_d = StT1;
        end
      end
      StT1: begin
        a_d = Q0;
        b_d = Q1;
        if (op_illegal) begin
          // Skip execute; T3 completes without writing.
          state_d = StT3;
        end else if (op == OpLoad) begin
          g_d     = DIN;
          state_d = StT3;
        end else begin
          state_d = StT2;
        end
      end
      StT2: begin
        g_d = alu_res;
`ifdef RFSEQ_FLAGS_EN
        if ((op == OpAdd) || (op == OpSub)) begin
          z_d = (alu_res == '0);
          c_d = alu_carry;
        end
`endif
        state_d = StT3;
      end
      StT3: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any instruction in flight.
  always_ff @(posedge CLKb or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      g_q     <= '0;
`ifdef RFSEQ_FLAGS_EN
      z_q     <= 1'b0;
      c_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      g_q     <= g_d;
`ifdef RFSEQ_FLAGS_EN
      z_q     <= z_d;
      c_q     <= c_d;
`endif
    end
  end

  // Moore output decode from state and latched instruction.
  always_comb begin
    D    = '0;
    ENW  = 1'b0;
    ENR0 = 1'b0;
    WRA  = '0;
    RDA0 = '0;
    RDA1 = '0;
    DONE = 1'b0;
    unique case (state_q)
      StT1: begin
        RDA0 = rx;
        RDA1 = ry;
        ENR0 = 1'b1;
      end
      StT3: begin
        D    = g_q;
        WRA  = rx;
        ENW  = ~op_illegal;
        DONE = 1'b1;
      end
      default: begin
        D    = '0;
        ENW  = 1'b0;
      end
    endcase
  end

  assign BUSY = (state_q != StIdle);

`ifdef RFSEQ_FLAGS_EN
  assign Z = z_q;
  assign C = c_q;
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer: a bench-side register file, an instruction-level
// reference model producing the expected per-cycle outputs, and directed literal checks.
module tb_regfile_sequencer;

  logic       CLKb;
  logic       RST;
  logic [9:0] INSTR;
  logic       EXECUTE;
  logic [9:0] DIN;
  logic [9:0] Q0;
  logic [9:0] Q1;
  logic [9:0] D;
  logic       ENW;
  logic       ENR0;
  logic [2:0] WRA;
  logic [2:0] RDA0;
  logic [2:0] RDA1;
  logic       BUSY;
  logic       DONE;
`ifdef RFSEQ_FLAGS_EN
  logic       Z;
  logic       C;
`endif

  regfile_sequencer #(.W(10), .AW(3)) dut (
    .CLKb    (CLKb),
    .RST     (RST),
    .INSTR   (INSTR),
    .EXECUTE (EXECUTE),
    .DIN     (DIN),
    .Q0      (Q0),
    .Q1      (Q1),
    .D       (D),
    .ENW     (ENW),
    .ENR0    (ENR0),
    .WRA     (WRA),
    .RDA0    (RDA0),
    .RDA1    (RDA1),
    .BUSY    (BUSY),
`ifdef RFSEQ_FLAGS_EN
    .Z       (Z),
    .C       (C),
`endif
    .DONE    (DONE)
  );

  initial CLKb = 1'b0;
  always #5 CLKb = ~CLKb;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file the sequencer drives; not cleared by RST.
  logic [9:0] rf [8] = '{default: 10'h000};
  always @(posedge CLKb) if (ENW) rf[WRA] <= D;
  assign Q0 = rf[RDA0];
  assign Q1 = rf[RDA1];

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [9:0] d;
    logic       enw;
    logic       enr0;
    logic [2:0] wra;
    logic [2:0] rda0;
    logic [2:0] rda1;
    logic       busy;
    logic       done;
    logic       setf;
    logic       fz;
    logic       fc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur = '0;
  logic [9:0] mrf [8] = '{default: 10'h000};
  logic [9:0] mg = '0;
  logic       mz = 1'b0;
  logic       mc = 1'b0;

  // Expand one instruction into its expected cycle-by-cycle outputs.
  task automatic build(input logic [9:0] ins, input logic [9:0] din);
    logic [3:0]  op;
    logic [2:0]  rx, ry;
    logic [9:0]  a, b, res;
    logic [10:0] wide;
    logic        cy, legal;
    exp_t        e;
    op = ins[9:6];
    rx = ins[5:3];
    ry = ins[2:0];
    a  = mrf[rx];
    b  = mrf[ry];
    legal = (op < 4'd8);
    cy  = 1'b0;
    res = '0;
    case (op)
      4'd0: res = din;
      4'd1: res = b;
      4'd2: begin wide = {1'b0, a} + {1'b0, b}; res = wide[9:0]; cy = wide[10]; end
      4'd3: begin res = a - b; cy = (a < b); end
      4'd4: res = ~b;
      4'd5: res = a & b;
      4'd6: res = a | b;
      4'd7: res = a ^ b;
      default: res = '0;
    endcase
    e = '0; e.enr0 = 1'b1; e.rda0 = rx; e.rda1 = ry; e.busy = 1'b1;
    exp_q.push_back(e);
    if (legal && op != 4'd0) begin
      e = '0; e.busy = 1'b1;
      exp_q.push_back(e);
    end
    e = '0; e.busy = 1'b1; e.done = 1'b1; e.wra = rx; e.enw = legal;
    e.d = legal ? res : mg;
    e.setf = (op == 4'd2) || (op == 4'd3);
    e.fz = (res == 10'h000);
    e.fc = cy;
    exp_q.push_back(e);
  endtask

  // Advance the model by one clock, or clear it on reset.
  always @(posedge CLKb or posedge RST) begin
    if (RST) begin
      exp_q.delete();
      cur = '0;
      mg  = '0;
      mz  = 1'b0;
      mc  = 1'b0;
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      if (cur.done && cur.enw) mg = cur.d;
      if (cur.setf) begin mz = cur.fz; mc = cur.fc; end
    end else if (cur.busy) begin
      if (cur.enw) mrf[cur.wra] = cur.d;
      cur = '0;
    end else if (EXECUTE) begin
      build(INSTR, DIN);
      cur = exp_q.pop_front();
    end else begin
      cur = '0;
    end
  end

  // Compare DUT outputs with the model every cycle outside reset.
  always @(negedge CLKb) begin
    if (!RST) begin
      check("D",    32'(D),    32'(cur.d));
      check("ENW",  32'(ENW),  32'(cur.enw));
      check("ENR0", 32'(ENR0), 32'(cur.enr0));
      check("WRA",  32'(WRA),  32'(cur.wra));
      check("RDA0", 32'(RDA0), 32'(cur.rda0));
      check("RDA1", 32'(RDA1), 32'(cur.rda1));
      check("BUSY", 32'(BUSY), 32'(cur.busy));
      check("DONE", 32'(DONE), 32'(cur.done));
`ifdef RFSEQ_FLAGS_EN
      check("Z",    32'(Z),    32'(mz));
      check("C",    32'(C),    32'(mc));
`endif
    end
  end

  // ---------------- stimulus ----------------
  int         lat;
  logic [9:0] d_done;
  logic [2:0] wra_done;
  logic       enw_done;
  logic       enr0_t1;

  // Issue one instruction from IDLE and return its observed timing and write-back values.
  task automatic issue(input logic [9:0] ins, input logic [9:0] din);
    logic found;
    found = 1'b0;
    lat = 0;
    @(posedge CLKb); #1;
    INSTR = ins; DIN = din; EXECUTE = 1'b1;
    @(posedge CLKb); #1;
    EXECUTE = 1'b0;
    enr0_t1 = ENR0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLKb);
      if (DONE) begin
        lat = i + 1; d_done = D; wra_done = WRA; enw_done = ENW;
        found = 1'b1;
        break;
      end
    end
    if (!found) check("done_timeout", 32'd0, 32'd1);
    @(posedge CLKb); #1;
  endtask

  initial begin
    RST = 1'b1; EXECUTE = 1'b0; INSTR = '0; DIN = '0;
    #1;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_enw",  32'(ENW),  32'd0);
    check("rst_d",    32'(D),    32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    repeat (2) @(posedge CLKb);
    #1 RST = 1'b0;

    issue(10'h008, 10'h3FF);                     // LOAD R1
    issue(10'h010, 10'h001);                     // LOAD R2
    issue(10'h018, 10'h155);                     // LOAD R3
    check("load_enr0", 32'(enr0_t1), 32'd1);
    check("load_lat",  32'(lat), 32'd2);
    check("load_d",    32'(d_done), 32'h155);
    check("load_wra",  32'(wra_done), 32'd3);
    check("load_enw",  32'(enw_done), 32'd1);

    issue(10'h08A, 10'h000);                     // ADD R1,R2 -> wraps to 0
    check("add_lat", 32'(lat), 32'd3);
    check("add_d",   32'(d_done), 32'h000);
    check("add_wra", 32'(wra_done), 32'd1);
`ifdef RFSEQ_FLAGS_EN
    check("add_z", 32'(Z), 32'd1);
    check("add_c", 32'(C), 32'd1);
`endif

    issue(10'h020, 10'h005);                     // LOAD R4
    issue(10'h028, 10'h007);                     // LOAD R5
    issue(10'h0E5, 10'h000);                     // SUB R4,R5
    check("sub_d",   32'(d_done), 32'h3FE);
    check("sub_wra", 32'(wra_done), 32'd4);
`ifdef RFSEQ_FLAGS_EN
    check("sub_z", 32'(Z), 32'd0);
    check("sub_c", 32'(C), 32'd1);
`endif

    issue(10'h073, 10'h000);                     // MOV R6,R3
    issue(10'h13B, 10'h000);                     // INV R7,R3
    check("inv_d", 32'(d_done), 32'h2AA);
    issue(10'h15E, 10'h000);                     // AND R3,R6
    issue(10'h1BB, 10'h000);                     // OR  R7,R3
    issue(10'h1F3, 10'h000);                     // XOR R6,R3
    issue(10'h092, 10'h000);                     // ADD R2,R2
    check("dbl_d", 32'(d_done), 32'h002);

    // EXECUTE held with INSTR changed mid-instruction: the new INSTR is ignored.
    @(posedge CLKb); #1;
    INSTR = 10'h0AC; EXECUTE = 1'b1;             // ADD R5,R4
    @(posedge CLKb); #1;
    INSTR = 10'h200;
    @(posedge CLKb); #1;
    @(posedge CLKb); #1;
    EXECUTE = 1'b0;
    check("busy_done", 32'(DONE), 32'd1);
    check("busy_d",    32'(D), 32'h005);
    check("busy_wra",  32'(WRA), 32'd5);
    repeat (2) @(posedge CLKb);
    #1;
    check("busy_idle", 32'(BUSY), 32'd0);

    issue(10'h200, 10'h000);                     // illegal opcode
    check("ill_lat", 32'(lat), 32'd2);
    check("ill_enw", 32'(enw_done), 32'd0);

    // Back-to-back LOAD R0 with EXECUTE held.
    @(posedge CLKb); #1;
    INSTR = 10'h000; DIN = 10'h2AB; EXECUTE = 1'b1;
    repeat (6) @(posedge CLKb);
    #1 EXECUTE = 1'b0;
    repeat (2) @(posedge CLKb);
    #1;

    // Abort: reset during T2 of ADD R2,R3.
    @(posedge CLKb); #1;
    INSTR = 10'h093; EXECUTE = 1'b1;
    @(posedge CLKb); #1;
    EXECUTE = 1'b0;
    @(posedge CLKb); #3;
    RST = 1'b1;
    #1;
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_enw",  32'(ENW),  32'd0);
    @(posedge CLKb); #1;
    RST = 1'b0;
    repeat (3) @(posedge CLKb);
    #1;

    check("rf_r0", 32'(rf[0]), 32'h2AB);
    check("rf_r1", 32'(rf[1]), 32'h000);
    check("rf_r2", 32'(rf[2]), 32'h002);
    check("rf_r3", 32'(rf[3]), 32'h155);
    check("rf_r4", 32'(rf[4]), 32'h3FE);
    check("rf_r5", 32'(rf[5]), 32'h005);
    check("rf_r6", 32'(rf[6]), 32'h000);
    check("rf_r7", 32'(rf[7]), 32'h3FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
